mdu_ctrl: RTL and testbench

Multiply/divide controller for the execute stage: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, sequences a single-cycle multiplier and an iterative 32-step divider, and owns the architectural HI/LO registers. It raises a stall request toward the pipeline control while a long operation is in flight, and supports cancellation on pipeline flush.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_divider.sv | 67 ++++++
 rtl/mdu_ctrl.sv | 129 ++++++++++++
 tb/tb_mdu_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Op encoding, controller state encoding and divider step count.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_t;

  localparam int MDU_DIV_STEPS = 32;

  // Ops that hold the pipeline until HI/LO are written.
  function automatic logic is_long_op(mdu_op_t o);
    return (o == MDU_MULT) || (o == MDU_MULTU) || (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider: one quotient bit per step on operand magnitudes,
// with sign correction applied to the outputs of the step currently in progress.
module mdu_divider
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        step,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last_step,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_reg, quo_reg, dvsr_reg;
  logic [4:0]  cnt_reg;
  logic        neg_q_reg, neg_r_reg, dz_reg;

  logic        a_neg, b_neg, fits;
  logic [32:0] rem_shift, diff;
  logic [31:0] rem_next, quo_next;

  assign a_neg = is_signed & dividend[31];
  assign b_neg = is_signed & divisor[31];

  // The dividend bits shift out of the quotient register into the remainder.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[31]};
    diff      = rem_shift - {1'b0, dvsr_reg};
    fits      = (rem_shift >= {1'b0, dvsr_reg});
    rem_next  = fits ? diff[31:0] : rem_shift[31:0];
    quo_next  = {quo_reg[30:0], fits};
  end

  assign last_step = (cnt_reg == 5'(MDU_DIV_STEPS - 1));
  // Zero divisor: quotient forced to all ones, remainder naturally equals the dividend.
  assign quotient  = dz_reg ? 32'hFFFF_FFFF : (neg_q_reg ? -quo_next : quo_next);
  assign remainder = neg_r_reg ? -rem_next : rem_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvsr_reg  <= '0;
      cnt_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dz_reg    <= 1'b0;
    end else if (load) begin
      rem_reg   <= '0;
      quo_reg   <= a_neg ? -dividend : dividend;
      dvsr_reg  <= b_neg ? -divisor : divisor;
      cnt_reg   <= '0;
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
      dz_reg    <= (divisor == 32'd0);
    end else if (step) begin
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      cnt_reg   <= cnt_reg + 5'd1;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: FSM, multiplier operand latches, HI/LO registers,
// stall request and completion pulse; iterative divide delegated to mdu_divider.
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  mdu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t  state_reg, state_next;
  logic [31:0] mul_a_reg, mul_b_reg, hi_reg, lo_reg;
  logic        mul_signed_reg, done_reg;
  logic        accept, div_load, div_step, div_last;
  logic [31:0] div_q, div_r;
  logic [63:0] ext_a, ext_b, prod;

  // A start while done is high is the finished instruction still sitting in E.
  assign accept = start & ~flush & (state_reg == IDLE) & ~done_reg;

  always_comb begin
    state_next = state_reg;
    div_load   = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            case (op)
              MDU_MULT, MDU_MULTU: state_next = MUL;
              MDU_DIV, MDU_DIVU: begin
                state_next = DIV;
                div_load   = 1'b1;
              end
              default: state_next = IDLE;
            endcase
          end
        end
        MUL:     state_next = IDLE;
        DIV:     if (div_last) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
    busy = (accept & is_long_op(op)) | (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Sign-extend only for MULT so one 64-bit multiplier serves both flavours.
  assign ext_a = {{32{mul_signed_reg & mul_a_reg[31]}}, mul_a_reg};
  assign ext_b = {{32{mul_signed_reg & mul_b_reg[31]}}, mul_b_reg};
  assign prod  = ext_a * ext_b;

  assign div_step = (state_reg == DIV);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_a_reg      <= '0;
      mul_b_reg      <= '0;
      mul_signed_reg <= 1'b0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (!flush) begin
        case (state_reg)
          IDLE: begin
            if (accept) begin
              case (op)
                MDU_MULT, MDU_MULTU: begin
                  mul_a_reg      <= a;
                  mul_b_reg      <= b;
                  mul_signed_reg <= (op == MDU_MULT);
                end
                MDU_MTHI: hi_reg <= a;
                MDU_MTLO: lo_reg <= a;
                default: ;
              endcase
            end
          end
          MUL: begin
            hi_reg   <= prod[63:32];
            lo_reg   <= prod[31:0];
            done_reg <= 1'b1;
          end
          DIV: begin
            if (div_last) begin
              hi_reg   <= div_r;
              lo_reg   <= div_q;
              done_reg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  mdu_divider u_div (
    .clk       (clk),
    .resetn    (resetn),
    .load      (div_load),
    .step      (div_step),
    .is_signed (op == MDU_DIV),
    .dividend  (a),
    .divisor   (b),
    .last_step (div_last),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed and randomized checks of mdu_ctrl against an arithmetic reference
// model of HI/LO, with cycle-accurate busy/done expectations.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  mdu_op_t     op = MDU_MULT;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          total = 0, bad = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: architectural result of one op on the HI/LO model.
  task automatic model(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y);
    longint          ps, qs, rs;
    longint unsigned pu;
    case (o)
      MDU_MULT: begin
        ps = longint'($signed(x)) * longint'($signed(y));
        {hi_m, lo_m} = ps;
      end
      MDU_MULTU: begin
        pu = {32'd0, x} * {32'd0, y};
        {hi_m, lo_m} = pu;
      end
      MDU_DIV: begin
        if (y == 0) begin
          lo_m = 32'hFFFF_FFFF; hi_m = x;
        end else begin
          qs = longint'($signed(x)) / longint'($signed(y));
          rs = longint'($signed(x)) % longint'($signed(y));
          lo_m = qs[31:0]; hi_m = rs[31:0];
        end
      end
      MDU_DIVU: begin
        if (y == 0) begin
          lo_m = 32'hFFFF_FFFF; hi_m = x;
        end else begin
          lo_m = x / y; hi_m = x % y;
        end
      end
      MDU_MTHI: hi_m = x;
      MDU_MTLO: lo_m = x;
      default: ;
    endcase
  endtask

  // Present one op in cycle 0 and follow it to completion; hold keeps start high throughout.
  task automatic run_op(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y, input bit hold);
    int lat;
    bit is_long;
    is_long = (o == MDU_MULT) || (o == MDU_MULTU) || (o == MDU_DIV) || (o == MDU_DIVU);
    lat = (o == MDU_MULT || o == MDU_MULTU) ? 2 : 33;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    if (!is_long) begin
      check("mt_busy_c0", 32'(busy), 32'd0);
      model(o, x, y);
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      check("mt_done_c1", 32'(done), 32'd0);
      check("mt_hi_c1", hi, hi_m);
      check("mt_lo_c1", lo, lo_m);
    end else begin
      check("busy_c0", 32'(busy), 32'd1);
      for (int c = 1; c < lat; c++) begin
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        @(negedge clk);
        check("busy_run", 32'(busy), 32'd1);
        check("done_run", 32'(done), 32'd0);
      end
      model(o, x, y);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_end", 32'(done), 32'd1);
      check("busy_end", 32'(busy), 32'd0);
      check("hi_end", hi, hi_m);
      check("lo_end", lo, lo_m);
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      check("done_after", 32'(done), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
      check("hi_after", hi, hi_m);
      check("lo_after", lo, lo_m);
    end
    $display("tx op=%s a=%h b=%h hold=%0d hi=%h lo=%h", o.name(), x, y, hold, hi, lo);
  endtask

  initial begin
    mdu_op_t     ro;
    logic [31:0] rx, ry;

    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk); resetn = 1'b1;

    run_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(MDU_DIVU,  32'd100, 32'd7, 1'b0);
    run_op(MDU_DIVU,  32'h0000_1234, 32'd0, 1'b1);
    run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(MDU_DIV,   32'h8000_0000, 32'd0, 1'b0);
    run_op(MDU_MTHI,  32'hCAFE_F00D, 32'd0, 1'b0);

    // Flush a divide mid-flight, then MTLO right after.
    @(posedge clk); #1;
    start = 1'b1; op = MDU_DIV; a = 32'd12345; b = 32'd17;
    @(negedge clk);
    check("fl_busy_c0", 32'(busy), 32'd1);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      flush = (c == 10);
      if (c == 11) begin start = 1'b1; op = MDU_MTLO; a = 32'h55; end
      @(negedge clk);
      check("fl_done", 32'(done), 32'd0);
      check("fl_busy", 32'(busy), (c <= 10) ? 32'd1 : 32'd0);
      if (c == 11) begin
        check("fl_hi_kept", hi, hi_m);
        check("fl_lo_kept", lo, lo_m);
        lo_m = 32'h55;
      end
      if (c == 12) check("fl_mtlo", lo, lo_m);
    end
    start = 1'b0;
    $display("tx flush-div then MTLO hi=%h lo=%h", hi, lo);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; op = MDU_DIVU; a = 32'd999; b = 32'd4;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1; start = 1'b0;
    end
    @(posedge clk); #1; resetn = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_hi", hi, 32'd0);
    check("ar_lo", lo, 32'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk); resetn = 1'b1;
    $display("tx reset mid-DIVU hi=%h lo=%h", hi, lo);

    // MTHI presented while a divide is busy must be ignored.
    @(posedge clk); #1;
    start = 1'b1; op = MDU_DIVU; a = 32'd1000; b = 32'd3;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      start = (c == 4);
      if (c == 4) begin op = MDU_MTHI; a = 32'hDEAD_BEEF; end
      @(negedge clk);
      if (c == 5) check("mthi_ignored", hi, hi_m);
      if (c == 33) begin
        check("mb_done", 32'(done), 32'd1);
        check("mb_hi", hi, 32'd1);
        check("mb_lo", lo, 32'd333);
      end
    end
    hi_m = 32'd1; lo_m = 32'd333;
    start = 1'b0;
    $display("tx DIVU with ignored MTHI hi=%h lo=%h", hi, lo);

    for (int i = 0; i < 16; i++) begin
      ro = mdu_op_t'($urandom_range(0, 5));
      rx = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = 32'd0;
        1:       ry = $urandom_range(1, 40);
        default: ry = $urandom;
      endcase
      run_op(ro, rx, ry, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit reached");
  end

endmodule
